// File: rtl/i2s_rx_multi.sv
// Multi-line I2S receiver: deserialises CHANNELS stereo sd lines and streams
// the captured words one per handshake, tagged with channel number 2*line+side.
module i2s_rx_multi #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CW       = $clog2(2 * CHANNELS)
) (
    input  logic                ck,
    input  logic                rst_n,
    input  logic                sample,
    input  logic [5:0]          frame_posn,
    input  logic [CHANNELS-1:0] sd,
    input  logic                lj,
    input  logic                en,
    input  logic                clr_overrun,
    output logic [BITS-1:0]     out_data,
    output logic [CW-1:0]       out_chan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PW = 7;

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] shift_q [CHANNELS];
    logic [BITS-1:0] shift_d [CHANNELS];
    logic [BITS-1:0] hold_q  [CHANNELS];
    logic [BITS-1:0] hold_d  [CHANNELS];
    logic [IW-1:0]   idx_q, idx_d;
    logic            side_q, side_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic            ovr_q, ovr_d;

    logic [PW-1:0]   posn_c;
    logic [PW-1:0]   cap_l_c;
    logic [PW-1:0]   cap_r_c;
    logic            is_r_c;
    logic            cap_c;
    logic            hs_c;
    logic            last_c;

    // Capture positions widened to 7 bits: CAP_R can reach 64 and must then never match.
    assign posn_c  = PW'(frame_posn);
    assign cap_l_c = PW'(BITS) + (lj ? PW'(0) : PW'(1));
    assign cap_r_c = cap_l_c + PW'(32);
    assign is_r_c  = (posn_c == cap_r_c);
    assign cap_c   = sample && en && ((posn_c == cap_l_c) || is_r_c);

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = hold_q[idx_q];
    assign out_chan  = chan_q;
    assign overrun   = ovr_q;

    assign hs_c   = out_valid && out_ready;
    assign last_c = (idx_q == IW'(CHANNELS - 1));

    // Next-state: shifting, capture/drain sequencing and sticky overrun.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        side_d  = side_q;
        ovr_d   = ovr_q;

        if (sample) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shift_d[i] = {shift_q[i][BITS-2:0], sd[i]};
            end
        end

        if (clr_overrun) begin
            ovr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cap_c) begin
                    hold_d  = shift_q;
                    side_d  = is_r_c;
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_c) begin
                    // A capture landing on the final handshake is a clean hand-off.
                    hold_d = shift_q;
                    side_d = is_r_c;
                    idx_d  = '0;
                    if (!(hs_c && last_c)) begin
                        ovr_d = 1'b1;
                    end
                end else if (hs_c) begin
                    if (last_c) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
        endcase

        chan_d = CW'({idx_d, side_d});
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            side_q  <= 1'b0;
            chan_q  <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shift_q[i] <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            side_q  <= side_d;
            chan_q  <= chan_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shift_q[i] <= shift_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Directed bench for i2s_rx_multi (BITS=16, CHANNELS=2): framing modes,
// backpressure, overrun, coincident capture/handshake, reset and enable.
module tb_i2s_rx_multi;

    localparam int unsigned BITS     = 16;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned CW       = 2;

    logic                ck = 1'b0;
    logic                rst_n;
    logic                sample;
    logic [5:0]          frame_posn;
    logic [CHANNELS-1:0] sd;
    logic                lj;
    logic                en;
    logic                clr_overrun;
    logic [BITS-1:0]     out_data;
    logic [CW-1:0]       out_chan;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcount = 0;
    int gbase  = 0;
    int cap_l  = 0;
    int cap_r  = 0;

    logic [63:0] got_q [$];
    logic [63:0] exp_q [$];

    i2s_rx_multi #(.BITS(BITS), .CHANNELS(CHANNELS), .CW(CW)) dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .sample      (sample),
        .frame_posn  (frame_posn),
        .sd          (sd),
        .lj          (lj),
        .en          (en),
        .clr_overrun (clr_overrun),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input int c, input logic [1:0] ch, input logic [15:0] d);
        return 64'({c, ch, d});
    endfunction

    // Record every accepted word with the cycle in which it was offered.
    always @(negedge ck) begin
        if (out_valid) vcount++;
        if (out_valid && out_ready) got_q.push_back(mk(cyc, out_chan, out_data));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        n = got_q.size() - gbase;
        chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n) chk($sformatf("%s_w%0d", tag, i), got_q[gbase + i], exp_q[i]);
        end
        gbase = got_q.size();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        sample      = 1'b0;
        clr_overrun = 1'b0;
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    // One 64-strobe frame; line0 carries l0/r0, line1 carries l1/r1, MSB first.
    task automatic run_frame(input logic [15:0] l0, input logic [15:0] r0,
                             input logic [15:0] l1, input logic [15:0] r1,
                             input logic ljm, input logic enm,
                             input int rdy_posn, input int clr_posn, input bit stall_chk);
        int off;
        off = ljm ? 0 : 1;
        lj  = ljm;
        en  = enm;
        for (int p = 0; p < 64; p++) begin
            logic [1:0] b;
            b = 2'b00;
            if (p >= off && p < off + 16)
                b = {l1[15 - (p - off)], l0[15 - (p - off)]};
            if (p >= 32 + off && p < 48 + off)
                b = {r1[15 - (p - 32 - off)], r0[15 - (p - 32 - off)]};
            sample      = 1'b1;
            frame_posn  = 6'(p);
            sd          = b;
            out_ready   = (p >= rdy_posn);
            clr_overrun = (p == clr_posn);
            @(posedge ck);
            #1;
            if (p == 16 + off) cap_l = cyc;
            if (p == 48 + off) cap_r = cyc;
            if (stall_chk && p >= 16 + off && p < 26 + off)
                chk($sformatf("stall_p%0d", p), 64'({out_valid, out_chan, out_data}),
                    64'({1'b1, 2'd0, l0}));
        end
        sample      = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic exp_normal(input int l_at, input int r_at);
        exp_q.push_back(mk(l_at,     2'd0, 16'hA5C3));
        exp_q.push_back(mk(l_at + 1, 2'd2, 16'hFFFF));
        exp_q.push_back(mk(r_at,     2'd1, 16'h1234));
        exp_q.push_back(mk(r_at + 1, 2'd3, 16'h0001));
    endtask

    initial begin
        int c0;
        int vb;
        rst_n = 1'b0; sample = 1'b0; frame_posn = '0; sd = '0; lj = 1'b0;
        en = 1'b1; clr_overrun = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_chan", 64'(out_chan), 64'(0));
        chk("rst_ovr", 64'(overrun), 64'(0));
        rst_n = 1'b1;
        idle(2);

        // I2S framing, always ready
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, -1, 1'b0);
        idle(3);
        exp_normal(cap_l, cap_r);
        compare_q("i2s");
        chk("i2s_ovr", 64'(overrun), 64'(0));

        // Left-justified framing
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 0, -1, 1'b0);
        idle(3);
        exp_normal(cap_l, cap_r);
        compare_q("lj");
        chk("lj_ovr", 64'(overrun), 64'(0));

        // Backpressure: ready held low for 10 cycles after the left capture
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 27, -1, 1'b1);
        idle(3);
        exp_normal(cap_l + 9, cap_r);
        exp_q[1] = mk(cap_l + 10, 2'd2, 16'hFFFF);
        compare_q("bp");
        chk("bp_ovr", 64'(overrun), 64'(0));

        // Overrun: never ready across the frame
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 64, -1, 1'b0);
        chk("ovr_flag", 64'(overrun), 64'(1));
        chk("ovr_out", 64'({out_valid, out_chan, out_data}), 64'({1'b1, 2'd1, 16'h1234}));
        c0 = cyc;
        out_ready = 1'b1;
        idle(3);
        exp_q.push_back(mk(c0,     2'd1, 16'h1234));
        exp_q.push_back(mk(c0 + 1, 2'd3, 16'h0001));
        compare_q("ovr");
        clr_overrun = 1'b1;
        @(posedge ck);
        #1;
        clr_overrun = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'(0));

        // Overrun with clear in the same cycle: set wins
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 64, 49, 1'b0);
        chk("ovr_setwins", 64'(overrun), 64'(1));
        c0 = cyc;
        out_ready = 1'b1;
        idle(3);
        exp_q.push_back(mk(c0,     2'd1, 16'h1234));
        exp_q.push_back(mk(c0 + 1, 2'd3, 16'h0001));
        compare_q("ovr2");
        clr_overrun = 1'b1;
        @(posedge ck);
        #1;
        clr_overrun = 1'b0;
        chk("ovr2_clr", 64'(overrun), 64'(0));

        // Final handshake of the left drain lands on the right capture edge
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 48, -1, 1'b0);
        idle(3);
        exp_normal(cap_l + 30, cap_r);
        exp_q[1] = mk(cap_l + 31, 2'd2, 16'hFFFF);
        compare_q("coin");
        chk("coin_ovr", 64'(overrun), 64'(0));
        chk("coin_gap", 64'(cap_r - cap_l), 64'(32));

        // Reset while draining, with overrun set and a strobe on the reset edge
        run_frame(16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3, 1'b0, 1'b1, 64, -1, 1'b0);
        chk("pre_rst_ovr", 64'(overrun), 64'(1));
        rst_n = 1'b0; sample = 1'b1; frame_posn = 6'd17; out_ready = 1'b0;
        @(posedge ck);
        #1;
        rst_n = 1'b1; sample = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_chan", 64'(out_chan), 64'(0));
        chk("mid_rst_ovr", 64'(overrun), 64'(0));
        idle(2);
        gbase = got_q.size();

        // Enable low for a full frame: no captures
        vb = vcount;
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, -1, 1'b0);
        idle(3);
        chk("en0_valid_cycles", 64'(vcount - vb), 64'(0));
        compare_q("en0");

        // Captures resume on the next full frame
        run_frame(16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, -1, 1'b0);
        idle(3);
        exp_normal(cap_l, cap_r);
        compare_q("en1");
        chk("en1_ovr", 64'(overrun), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_multi.md
# i2s_rx_multi

Multi-line I2S receiver. It deserialises `CHANNELS` parallel I2S data lines, each carrying a stereo pair, into `BITS`-wide words, and supports both I2S (one-bit delay) and left-justified framing. Captured words are buffered and then streamed out one at a time on a valid/ready interface, tagged with the channel number. A sticky flag reports overrun. The block sits downstream of the shared I2S frame/bit-clock generator, which supplies `sample` and `frame_posn`, and feeds the DSP sample pipeline.

## Interface
- `BITS`, 16 — word width per channel, 2..31.
- `CHANNELS`, 4 — number of `sd` lines (stereo pairs), 1..8; output channels = 2*`CHANNELS`.
- `CW`, `$clog2(2*CHANNELS)` (min 1) — width of `out_chan`.

- `ck` input 1 — system clock; all logic on posedge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `sample` input 1 — one-cycle strobe; sample `sd` now.
- `frame_posn` input 6 — bit position in the 64-bit frame; 0..31 is left, 32..63 is right.
- `sd` input `CHANNELS` — I2S data lines; bit i is line i.
- `lj` input 1 — 0 selects I2S (MSB at posn 1/33); 1 selects left-justified (MSB at posn 0/32).
- `en` input 1 — 0 suppresses captures; shifting continues.
- `clr_overrun` input 1 — one-cycle pulse that clears `overrun`.
- `out_data` output `BITS` — word, MSB-first as received.
- `out_chan` output `CW` — 2*line + side; side 0 = left, 1 = right.
- `out_valid` output 1 — word available.
- `out_ready` input 1 — consumer accepts.
- `overrun` output 1 — sticky; a half-frame was captured before the previous drain finished.

## Operation
- **Shift.** On every cycle with `sample`=1, each line's `BITS`-wide shift register takes `{shift[BITS-2:0], sd[i]}`.
- **Capture position.** `CAP_L` = `BITS` + (`lj` ? 0 : 1) and `CAP_R` = `CAP_L` + 32. The capture uses the shift contents before this cycle's bit enters. This means bits sampled at posns `CAP_L-BITS` .. `CAP_L-1` form the word.
- **Capture event.** A capture event occurs when `sample` && `en` && `frame_posn` ∈ {`CAP_L`, `CAP_R`}. On that edge:
  - all shift registers copy into `hold[0..CHANNELS-1]`;
  - `side` ← (`frame_posn` == `CAP_R`);
  - `idx` ← 0;
  - state ← DRAIN.
- **State machine.**
  - IDLE: `out_valid`=0.
  - DRAIN: `out_valid`=1, `out_data`=`hold[idx]`, `out_chan`=2*`idx`+`side`.
  - Each handshake (`out_valid` && `out_ready`) advances `idx`. A handshake at `idx`==`CHANNELS-1` returns the machine to IDLE.
- **Overrun.** A capture event while in DRAIN, unless it coincides with the final handshake, does the following:
  - sets `overrun`;
  - discards the remaining undrained words;
  - reloads `hold`, `side` and `idx`=0, and stays in DRAIN.

  This is the only case where `out_data`/`out_chan` change while `out_valid` && !`out_ready`.
- **Capture coincident with final handshake.** The final word is accepted and the new drain starts the next cycle. No overrun.
- **Flag priority.** `clr_overrun` and an overrun event in the same cycle leave `overrun`=1 (set wins).
- **Mode changes.** `lj` and `en` are evaluated every cycle. Changing them mid-frame may drop or corrupt at most the current half-frame word. No lockup.
- **Ignored positions.** `frame_posn` values other than the two capture positions only shift. The shift register never clears between words.

## Timing
- **Reset** (`rst_n`=0 at a clock edge):
  - shift, `hold`, `idx`, `side` ← 0;
  - state ← IDLE;
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `overrun`=0;
  - `sample` is ignored on that edge.
- **Reset mid-drain.** Words are lost, and `out_valid` drops in the cycle after the reset edge.
- **Latency.** With a capture edge at cycle T, `out_valid`=1 with channel `side` (line 0) from cycle T+1. With `out_ready` held high, the last word is presented at cycle T+`CHANNELS` and `out_valid`=0 at T+`CHANNELS`+1.
- **Throughput.** One word per cycle. A drain must complete within the ≥32 `sample` strobes between captures. Consumers that stall longer cause an overrun.
- **Registered outputs.** `out_valid`, `out_chan` and `overrun` are driven from registers. `out_data` is a mux of registered `hold` by registered `idx`, with no combinational path from inputs.

## Test plan
- **I2S capture.** `BITS`=16, `CHANNELS`=2, `lj`=0. Line0 left=0xA5C3 at posns 1..16, right=0x1234 at 33..48; line1 left=0xFFFF, right=0x0001. With `out_ready`=1, the output sequence is (0,0xA5C3),(2,0xFFFF) one cycle after the posn-17 strobe, then (1,0x1234),(3,0x0001) after posn 49. `overrun`=0.
- **Left-justified.** Same data shifted one posn earlier, `lj`=1. Identical output words, with captures on the posn-16 and posn-48 strobes.
- **Backpressure.** `out_ready`=0 for 10 cycles after a capture. `out_valid`=1 and (chan 0, word) held stable. When ready rises, both words drain on consecutive cycles. No overrun.
- **Overrun.** `out_ready`=0 for a whole half-frame. At the right capture, `overrun`=1 and the output switches to (1, right word), left line1 dropped. A `clr_overrun` pulse then clears it. Repeat with `clr_overrun` in the overrun cycle and check `overrun`=1.
- **Coincident events.** The final handshake coincides with the next capture: no overrun, and the new word appears on the following cycle.
- **Reset and enable.** `rst_n`=0 during DRAIN, then `en`=0 for one frame. All outputs are 0 after reset and there is no `out_valid` while `en`=0. Captures resume on the first full half-frame after `en`=1.
